// File: rtl/tdm_pkg.sv
// Shared TDM definitions used by the demultiplexer and the matching serializer.
// ST_PARITY exists only when TDM_PARITY_EN is defined.
package tdm_pkg;

  localparam int SLOT_COUNT  = 4;
  localparam int SLOT_ADDR_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1
`ifdef TDM_PARITY_EN
    ,
    ST_PARITY = 2'd2
`endif
  } tdm_state_e;

endpackage

// File: rtl/tdm_slot_decoder.sv
// 2-to-4 one-hot decoder selecting which shadow slot takes the incoming bit.
module tdm_slot_decoder
  import tdm_pkg::*;
(
  input  logic                   en_i,
  input  logic [SLOT_ADDR_W-1:0] slot_i,
  output logic [SLOT_COUNT-1:0]  onehot_o
);

  generate
    for (genvar gi = 0; gi < SLOT_COUNT; gi++) begin : g_dec
      assign onehot_o[gi] = en_i && (slot_i == SLOT_ADDR_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/tdm_demultiplexer.sv
// Serial TDM stream (MSB-first) into four registered WIDTH-bit slot payloads.
// Define TDM_PARITY_EN to add an even-parity trailer bit checked before loading.
module tdm_demultiplexer
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             address0,
  output logic             address1,
  output logic             frame_valid,
  output logic             frame_abort,
  output logic             parity_error
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0]       LAST_BIT  = BIT_W'(WIDTH - 1);
  localparam logic [SLOT_ADDR_W-1:0] LAST_SLOT = SLOT_ADDR_W'(SLOT_COUNT - 1);

  tdm_state_e             state_q, state_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d, cur_bit;
  logic [SLOT_ADDR_W-1:0] slot_q, slot_d, cur_slot;
  logic [WIDTH-1:0]       shadow_q [SLOT_COUNT];
  logic [WIDTH-1:0]       shadow_d [SLOT_COUNT];
  logic [WIDTH-1:0]       out_q    [SLOT_COUNT];
  logic [SLOT_COUNT-1:0]  slot_en;
  logic                   frame_valid_q, frame_abort_q;
  logic                   final_bit, start, sample, abort, load;
`ifdef TDM_PARITY_EN
  logic                   par_q, par_d, par_ok, parity_fail, parity_error_q;
`endif

  assign final_bit = (slot_q == LAST_SLOT) && (bit_cnt_q == LAST_BIT);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (frame_start) state_d = ST_RECV;
`ifdef TDM_PARITY_EN
      ST_RECV:   if (final_bit) state_d = ST_PARITY;
      ST_PARITY: state_d = ST_IDLE;
`else
      ST_RECV:   if (final_bit) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // frame_start on the final data bit is plain data, never an abort
  always_comb begin
    start  = 1'b0;
    sample = 1'b0;
    abort  = 1'b0;
    load   = 1'b0;
`ifdef TDM_PARITY_EN
    parity_fail = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        start  = frame_start;
        sample = frame_start;
      end
      ST_RECV: begin
        sample = 1'b1;
        start  = frame_start && !final_bit;
        abort  = frame_start && !final_bit;
`ifndef TDM_PARITY_EN
        load   = final_bit;
`endif
      end
`ifdef TDM_PARITY_EN
      ST_PARITY: begin
        load        = par_ok;
        parity_fail = !par_ok;
      end
`endif
      default: ;
    endcase
  end

  // A (re)start samples the current bit as slot 0, bit 0 of the new frame
  always_comb begin
    cur_slot  = start ? '0 : slot_q;
    cur_bit   = start ? '0 : bit_cnt_q;
    slot_d    = '0;
    bit_cnt_d = '0;
    if (sample) begin
      if (cur_bit == LAST_BIT) begin
        slot_d = cur_slot + SLOT_ADDR_W'(1);
      end else begin
        slot_d    = cur_slot;
        bit_cnt_d = cur_bit + BIT_W'(1);
      end
    end
  end

  tdm_slot_decoder u_slot_decoder (
    .en_i     (sample),
    .slot_i   (cur_slot),
    .onehot_o (slot_en)
  );

  generate
    for (genvar gi = 0; gi < SLOT_COUNT; gi++) begin : g_shadow
      assign shadow_d[gi] = slot_en[gi] ? ((shadow_q[gi] << 1) | WIDTH'(serial_in))
                                        : shadow_q[gi];
    end
  endgenerate

`ifdef TDM_PARITY_EN
  assign par_ok = ~(par_q ^ serial_in);
  assign par_d  = start ? serial_in : (sample ? (par_q ^ serial_in) : par_q);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q     <= '0;
      slot_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_abort_q <= 1'b0;
      for (int i = 0; i < SLOT_COUNT; i++) begin
        shadow_q[i] <= '0;
        out_q[i]    <= '0;
      end
`ifdef TDM_PARITY_EN
      par_q          <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      slot_q        <= slot_d;
      frame_valid_q <= load;
      frame_abort_q <= abort;
      for (int i = 0; i < SLOT_COUNT; i++) begin
        shadow_q[i] <= shadow_d[i];
        if (load) out_q[i] <= shadow_d[i];
      end
`ifdef TDM_PARITY_EN
      par_q          <= par_d;
      parity_error_q <= parity_fail;
`endif
    end
  end

  assign out0        = out_q[0];
  assign out1        = out_q[1];
  assign out2        = out_q[2];
  assign out3        = out_q[3];
  assign address0    = slot_q[0];
  assign address1    = slot_q[1];
  assign frame_valid = frame_valid_q;
  assign frame_abort = frame_abort_q;
`ifdef TDM_PARITY_EN
  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: doc/tdm_demultiplexer.md
TDM_DEMULTIPLEXER -- requirements
Module: tdm_demultiplexer

Interface
REQ-001 Parameter: WIDTH, default 1, bits per slot, legal range 1..8.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: frame_start  input  1  marks the first bit of slot 0.
REQ-006 Port: serial_in  input  1  TDM bit stream, MSB-first within each slot.
REQ-007 Ports: out0, out1, out2, out3  output  WIDTH each  registered slot payloads.
REQ-008 Ports: address0, address1  output  1 each  slot currently being received.
REQ-009 Port: frame_valid  output  1  one-cycle pulse when out0..out3 update.
REQ-010 Port: frame_abort  output  1  one-cycle pulse when a partial frame is discarded.
REQ-011 Port: parity_error  output  1  one-cycle pulse on a rejected frame.

Function
REQ-012 The block SHALL implement states IDLE and RECV, plus PARITY only when REQ-027 applies.
REQ-013 In IDLE with frame_start=1, the block SHALL sample serial_in as slot 0 bit WIDTH-1 and go to RECV.
REQ-014 In RECV, the block SHALL sample one bit per cycle; the bit counter wraps at WIDTH, then the slot counter {address1,address0} increments.
REQ-015 address1:address0 SHALL show the slot of the next bit to be sampled, and SHALL read 0 in IDLE.
REQ-016 Completing a frame: on the edge that samples the last bit of slot 3, out0..out3 SHALL load simultaneously, and frame_valid=1 for the following cycle.
REQ-017 Latency: frame_valid SHALL occur 4*WIDTH cycles after the frame_start cycle.
REQ-018 out0..out3 SHALL hold their values between frame completions; partial frames SHALL never reach the outputs.
REQ-019 Back-to-back frames: frame_start in the cycle after the last bit SHALL start a new frame with no gap.
REQ-020 Otherwise, after the last bit, the block SHALL return to IDLE.
REQ-021 frame_start=1 while in RECV at a non-final bit SHALL discard the partial frame, restart at slot 0 with the current bit, and pulse frame_abort; outputs SHALL be unchanged.
REQ-022 frame_start on the final bit of a frame SHALL be treated as data; the frame SHALL complete normally.
REQ-023 serial_in in IDLE without frame_start SHALL be ignored.

Reset
REQ-024 Reset SHALL return the block to IDLE and clear the counters and shadow register.
REQ-025 Reset SHALL clear out0..out3, address0, address1, frame_valid, frame_abort and parity_error to 0.
REQ-026 Reset SHALL take priority over frame_start, and a frame interrupted by reset SHALL produce no pulse.

Configuration
REQ-027 With TDM_PARITY_EN defined, one PARITY cycle SHALL follow slot 3 and sample an even-parity bit covering all 4*WIDTH data bits.
REQ-028 With TDM_PARITY_EN, outputs SHALL load and frame_valid SHALL pulse only on correct parity; otherwise parity_error SHALL pulse and outputs SHALL hold.
REQ-029 With TDM_PARITY_EN, latency SHALL be 4*WIDTH+1 cycles, and frame_start during the PARITY cycle SHALL be treated as the parity bit.
REQ-030 Without TDM_PARITY_EN, the PARITY state SHALL be absent and parity_error SHALL be tied to 0.

Structure
REQ-031 Shared package tdm_pkg SHALL hold the state enum, SLOT_COUNT=4 and SLOT_ADDR_W=2, for reuse by the matching TDM serializer.
REQ-032 Sub-module tdm_slot_decoder (2-to-4 one-hot decoder) SHALL drive the shadow-register slot enables from the slot counter.

Verification (WIDTH=1 unless stated)
REQ-033 Reset with any inputs -> all outputs 0, address 00, no pulses.
REQ-034 frame_start at cycle 0, serial 1,0,1,1 -> out0..out3=1,0,1,1 and frame_valid high in cycle 4 only.
REQ-035 Frame 1010 followed immediately by 0101 -> frame_valid at cycles 4 and 8, outputs 1,0,1,0 then 0,1,0,1.
REQ-036 frame_start again at slot 2 -> frame_abort pulse, outputs unchanged, new frame captured 4 cycles later.
REQ-037 Reset asserted at slot 2 -> IDLE, outputs 0, no frame_valid.
REQ-038 TDM_PARITY_EN, data 1,1,1,0 with parity 1 -> frame_valid at cycle 5; with parity 0 -> parity_error at cycle 5, outputs hold.
